// File: rtl/cv32e40p_rf_ctx_engine.sv
// cv32e40p_rf_ctx_engine: register file context save/restore sequencer streaming x[FIRST_REG..LAST_REG]
module cv32e40p_rf_ctx_engine #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_req_i,
  input  logic                  restore_req_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] sig_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  tx_valid_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  tx_ready_i,
  input  logic                  rx_valid_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  rx_ready_o
);
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
  localparam logic [ADDR_WIDTH:0] FIRST = (ADDR_WIDTH+1)'(FIRST_REG);
  localparam logic [ADDR_WIDTH:0] LAST  = (ADDR_WIDTH+1)'(LAST_REG);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
  state_t state, state_nx;
  logic [ADDR_WIDTH:0] idx;
  logic words_left, ld, hs, start;
  assign words_left = idx <= LAST;
  assign start = (state == IDLE) && (save_req_i || restore_req_i);
  assign ld = (state == SAVE) && (!tx_valid_o || tx_ready_i) && words_left && !abort_i;
  assign hs = rx_valid_i && rx_ready_o && !abort_i;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: abort wins over progress, save wins over restore
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = save_req_i ? SAVE : restore_req_i ? RESTORE : IDLE;
      SAVE:    state_nx = abort_i ? IDLE : (tx_valid_o && tx_ready_i && !words_left) ? DONE : SAVE;
      RESTORE: state_nx = abort_i ? IDLE : (hs && idx == LAST) ? DONE : RESTORE;
      default: state_nx = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    busy_o     = state != IDLE;
    done_o     = state == DONE;
    rx_ready_o = (state == RESTORE) && words_left;
    rf_raddr_o = (state == SAVE) ? idx[ADDR_WIDTH-1:0] : '0;
  end
  // datapath: index, signature, tx skid register and port B write register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= FIRST;
      sig_o      <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o    <= hs;
      tx_valid_o <= (state == SAVE && !abort_i) ? (ld || (tx_valid_o && !tx_ready_i)) : 1'b0;
      if (start) begin
        idx   <= FIRST;
        sig_o <= '0;
      end else if (state == DONE || abort_i) begin
        idx <= FIRST;
      end else if (ld) begin
        idx       <= idx + ONE;
        sig_o     <= sig_o ^ rf_rdata_i;
        tx_data_o <= rf_rdata_i;
      end else if (hs) begin
        idx        <= idx + ONE;
        sig_o      <= sig_o ^ rx_data_i;
        rf_waddr_o <= idx[ADDR_WIDTH-1:0];
        rf_wdata_o <= rx_data_i;
      end
    end
  end
endmodule

// File: tb/tb_cv32e40p_rf_ctx_engine.sv
// tb_cv32e40p_rf_ctx_engine: scoreboard bench for the register file context engine
module tb_cv32e40p_rf_ctx_engine;
  logic clk = 1'b0, rst = 1'b1, save_req = 1'b0, restore_req = 1'b0, abort = 1'b0;
  logic tx_ready = 1'b0, rx_valid = 1'b0, rf_init = 1'b0;
  logic [31:0] rx_data = '0;
  logic busy, done, rf_we, tx_valid, rx_ready;
  logic [31:0] sig, rf_rdata, rf_wdata, tx_data;
  logic [4:0] rf_raddr, rf_waddr;
  logic [31:0] rf [32];
  int tests = 0, fails = 0, tx_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [31:0] exp_tx [$];
  logic [36:0] exp_wr [$];

  cv32e40p_rf_ctx_engine dut (
    .clk(clk), .rst(rst), .save_req_i(save_req), .restore_req_i(restore_req), .abort_i(abort),
    .busy_o(busy), .done_o(done), .sig_o(sig), .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_raddr];

  // register file model: preload x[i]=i*0x11111111, then absorb port B writes
  always @(posedge clk) begin
    if (rf_init) for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h11111111;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: pops scoreboards on accepted tx beats and port B writes, checks stall stability
  initial begin
    logic prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          check("tx_hold_valid", tx_valid, 1);
          check("tx_hold_data", tx_data, prev_data);
        end
        prev_stall = tx_valid & !tx_ready & !abort;
        prev_data = tx_data;
        if (tx_valid && tx_ready) begin
          tx_cnt++;
          if (exp_tx.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_extra: got %h want none", tx_data);
          end else check("tx_data", tx_data, exp_tx.pop_front());
        end
        if (rf_we) begin
          wr_cnt++;
          if (exp_wr.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_extra: got %h/%h want none", rf_waddr, rf_wdata);
          end else check("wr", {rf_waddr, rf_wdata}, exp_wr.pop_front());
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic start(input logic s, input logic r);
    @(posedge clk); #1 save_req = s; restore_req = r;
    @(posedge clk); #1 save_req = 1'b0; restore_req = 1'b0;
  endtask

  task automatic run_save(input logic both, input logic toggle);
    logic [31:0] x = '0;
    int d0 = done_cnt;
    for (int i = 1; i < 32; i++) begin
      exp_tx.push_back(32'(i) * 32'h11111111);
      x ^= 32'(i) * 32'h11111111;
    end
    tx_ready = 1'b1;
    start(1'b1, both);
    @(negedge clk);
    check("save_busy", busy, 1);
    check("save_raddr", rf_raddr, 1);
    check("save_sig_clr", sig, 0);
    check("save_first_early", tx_valid, 0);
    @(negedge clk);
    check("save_first_valid", tx_valid, 1);
    for (int c = 0; c < 400 && busy; c++) begin
      @(posedge clk); #1;
      tx_ready = !toggle || (c % 3 == 2);
      restore_req = !toggle && (c == 5);
    end
    restore_req = 1'b0;
    check("save_timeout", busy, 0);
    @(posedge clk); #1;
    check("save_req_ignored", busy, 0);
    check("save_done", done_cnt, d0 + 1);
    check("save_left", exp_tx.size(), 0);
    check("save_sig", sig, x);
    tx_ready = 1'b0;
  endtask

  task automatic run_restore(input int n);
    logic [31:0] x = '0;
    logic hs;
    int k = 1;
    int w0 = wr_cnt;
    int d0 = done_cnt;
    for (int i = 1; i <= n; i++) begin
      exp_wr.push_back({5'(i), 32'hA5A50000 + 32'(i)});
      x ^= 32'hA5A50000 + 32'(i);
    end
    start(1'b0, 1'b1);
    for (int c = 0; c < 600 && k <= n; c++) begin
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data = 32'hA5A50000 + 32'(k);
      @(negedge clk); hs = rx_valid & rx_ready;
      @(posedge clk); #1;
      if (hs) k++;
    end
    rx_valid = 1'b0;
    check("rx_timeout", k, n + 1);
    if (n == 31) begin
      for (int c = 0; c < 10 && busy; c++) @(posedge clk);
      #1;
      check("rst_idle", busy, 0);
      check("rst_done", done_cnt, d0 + 1);
      check("rst_writes", wr_cnt, w0 + 31);
      check("rst_left", exp_wr.size(), 0);
      check("rst_sig", sig, x);
      check("rf_x1", rf[1], 32'hA5A50001);
      check("rf_x31", rf[31], 32'hA5A5001F);
      check("rf_x0", rf[0], 0);
    end
  endtask

  initial begin
    int t0, d0;
    rf_init = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rf_init = 1'b0;
    @(negedge clk);
    check("reset_state", {busy, done, rf_we, tx_valid, rx_ready, rf_raddr, sig}, 0);
    check("reset_regs", {rf_waddr, rf_wdata}, 0);
    run_save(1'b1, 1'b0);
    run_save(1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) exp_tx.push_back(32'(i) * 32'h11111111);
    t0 = tx_cnt;
    d0 = done_cnt;
    tx_ready = 1'b1;
    start(1'b1, 1'b0);
    for (int c = 0; c < 100 && tx_cnt < t0 + 10; c++) @(posedge clk);
    #1 tx_ready = 1'b0; abort = 1'b1;
    check("abort_beats", tx_cnt, t0 + 10);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_txv", tx_valid, 0);
    repeat (3) @(posedge clk);
    check("abort_nodone", done_cnt, d0);
    check("abort_left", exp_tx.size(), 0);
    run_save(1'b0, 1'b0);
    run_restore(5);
    for (int c = 0; c < 20 && exp_wr.size() != 0; c++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_state", {busy, done, rf_we, tx_valid, rx_ready, rf_raddr, sig}, 0);
    check("rst_mid_regs", {rf_waddr, rf_wdata}, 0);
    repeat (5) @(posedge clk);
    check("rst_mid_left", exp_wr.size(), 0);
    run_restore(31);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
